// File: rtl/rr_arbiter8.sv
// ============================================================================
//  Module   : rr_arbiter8
//  Purpose  : Eight-way round-robin arbiter, registered one-hot grant with
//             valid/ready handshake and a bounded per-owner beat budget.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter8 #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    input  logic         gnt_ready
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_HOLD - 1);

    state_t       state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [3:0]   beats_q, beats_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic         gnt_valid_q, gnt_valid_d;

    logic [2:0]   owner;
    logic         handshake;
    logic         do_release;

    // Scan ptr+1 .. ptr+8 (mod 8); iterating downwards lets the nearest hit win.
    // ptr itself is visited last, so the previous owner wins only when alone.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        pick = p;
        for (int i = 8; i >= 1; i--) begin
            idx = p + 3'(i);
            if (r[idx]) begin
                pick = idx;
            end
        end
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        onehot = 8'd1 << idx;
    endfunction

    always_comb begin
        owner = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                owner = 3'(i);
            end
        end
    end

    assign handshake  = gnt_valid_q & gnt_ready;
    assign do_release = handshake & (~req[owner] | (beats_q == LAST_BEAT));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        beats_d = beats_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = onehot(pick(req, ptr_q));
                    beats_d = 4'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (do_release) begin
                    ptr_d   = owner;
                    beats_d = 4'd0;
                    if (|req) begin
                        // Rotation uses the owner being released, not the stale ptr.
                        gnt_d = onehot(pick(req, owner));
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (handshake) begin
                    beats_d = beats_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                beats_d = 4'd0;
            end
        endcase
        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd7;
            beats_q     <= 4'd0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            beats_q     <= beats_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;

`ifndef SYNTHESIS
    a_onehot : assert property (@(posedge clk) disable iff (!resetn) $onehot0(gnt_q));
    a_valid  : assert property (@(posedge clk) disable iff (!resetn) gnt_valid_q == (|gnt_q));
    a_beats  : assert property (@(posedge clk) disable iff (!resetn) beats_q < 4'(MAX_HOLD));
    a_stable : assert property (@(posedge clk) disable iff (!resetn)
                                (state_q == BUSY && !handshake) |=> $stable(gnt_q));
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: reset, rotation, backpressure, wrap, sole
// requester and asynchronous mid-burst reset, with hand-computed grants.
`default_nettype none

module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] req = 8'h00;
    logic       gnt_ready = 1'b0;
    logic [7:0] gnt;
    logic       gnt_valid;

    int total = 0;
    int bad   = 0;

    rr_arbiter8 #(.N(8), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_ready (gnt_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_gnt(input string tag, input logic [7:0] exp);
        check({tag, ".gnt"}, gnt, exp);
        check({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, |exp});
    endtask

    initial begin
        // Reset and first grant
        tick();
        check_gnt("in_reset", 8'h00);
        tick();
        resetn = 1'b1;
        tick();
        check_gnt("idle_no_req", 8'h00);
        req = 8'hFF;
        tick();
        check_gnt("first_grant", 8'h01);

        // Full rotation: 4 beats per owner, no bubbles, wrap back to 0
        gnt_ready = 1'b1;
        for (int s = 1; s <= 32; s++) begin
            tick();
            check_gnt($sformatf("rot%0d", s), 8'h01 << ((s / 4) % 8));
        end
        req = 8'h00;
        gnt_ready = 1'b0;
        tick();
        check_gnt("hold_no_ready", 8'h01);
        gnt_ready = 1'b1;
        tick();
        check_gnt("release_to_idle", 8'h00);

        // Backpressure with early drop of req
        gnt_ready = 1'b0;
        req = 8'h10;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check_gnt($sformatf("bp%0d", c), 8'h10);
            if (c == 2) req = 8'h00;
        end
        gnt_ready = 1'b1;
        tick();
        check_gnt("bp_release", 8'h00);

        // Wrap fairness around owner 3
        gnt_ready = 1'b0;
        req = 8'h08;
        tick();
        check_gnt("wrap_own3", 8'h08);
        req = 8'h0A;
        gnt_ready = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_gnt($sformatf("wrap_hold3_%0d", c), 8'h08);
        end
        tick();
        check_gnt("wrap_to1", 8'h02);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_gnt($sformatf("wrap_hold1_%0d", c), 8'h02);
        end
        tick();
        check_gnt("wrap_to3", 8'h08);
        req = 8'h00;
        tick();
        check_gnt("wrap_idle", 8'h00);

        // Sole requester re-grant, then requester 0 joins during the 2nd beat
        req = 8'h80;
        tick();
        check_gnt("sole_grant", 8'h80);
        for (int c = 1; c <= 4; c++) begin
            tick();
            check_gnt($sformatf("sole%0d", c), 8'h80);
        end
        tick();
        check_gnt("sole_beat2", 8'h80);
        req = 8'h81;
        tick();
        check_gnt("sole_beat3", 8'h80);
        tick();
        check_gnt("sole_beat4", 8'h80);
        tick();
        check_gnt("sole_to0", 8'h01);

        // Async reset mid-burst while requester 2 owns the grant
        req = 8'h04;
        tick();
        check_gnt("pre_reset", 8'h04);
        gnt_ready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_gnt("async_reset", 8'h00);
        req = 8'h81;
        tick();
        check_gnt("reset_held", 8'h00);
        resetn = 1'b1;
        tick();
        check_gnt("post_reset", 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
